clarvi_mem_responder: RTL and testbench

CLARVI_MEM_RESPONDER -- requirements
Module: clarvi_mem_responder

---
 rtl/clarvi_mem_responder.sv | 159 +++++++++++++++
 tb/tb_clarvi_mem_responder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clarvi_mem_responder.sv
// Avalon-MM style 64-bit memory slave: byte-lane writes, in-order pipelined reads, sticky error flags.
// Reads respond READ_LATENCY edges after acceptance; waitrequest stalls each request WAIT_CYCLES cycles.
`timescale 1ns/1ps
module clarvi_mem_responder #(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2,
  parameter int WAIT_CYCLES  = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  byteenable,
  input  logic [63:0] writedata,
  output logic        waitrequest,
  output logic [63:0] readdata,
  output logic        readdatavalid,
  input  logic        error_clear,
  output logic        out_of_range,
  output logic        protocol_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 2'(WAIT_CYCLES - 1) : 2'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;

  logic          request;
  logic          accept;
  logic          acc_write;
  logic          acc_read;
  logic          addr_oor;
  logic [AW-1:0] word_idx;
  logic [63:0]   rd_word;
  logic          drop_evt;
  logic          rw_evt;
  logic          unused_addr_bits;

  logic [63:0] mem [DEPTH];

  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [63:0]             pipe_dat_q [READ_LATENCY];
  logic [63:0]             pipe_dat_d [READ_LATENCY];

  logic oor_q, oor_d;
  logic perr_q, perr_d;

  assign request          = read | write;
  assign word_idx         = address[AW+2:3];
  assign addr_oor         = |address[63:AW+3];
  assign unused_addr_bits = ^address[2:0];

  // Held high through reset so no master can slip a request past an unready slave.
  always_comb begin
    waitrequest = 1'b1;
    if (reset_n) begin
      if (state_q == S_IDLE) waitrequest = request && (WAIT_CYCLES > 0);
      else                   waitrequest = (cnt_q != 2'd0);
    end
  end

  assign accept    = request && !waitrequest;
  assign acc_write = accept && write;
  assign acc_read  = accept && read && !write;
  assign drop_evt  = (state_q == S_WAIT) && !request;
  assign rw_evt    = accept && read && write;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (request && (WAIT_CYCLES > 0)) begin
            state_q <= S_WAIT;
            cnt_q   <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (!request || (cnt_q == 2'd0)) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 2'd0;
        end
      endcase
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (acc_write && !addr_oor) begin
      for (int i = 0; i < 8; i++) begin
        if (byteenable[i]) mem[word_idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  assign rd_word = addr_oor ? 64'd0 : mem[word_idx];

  // Idle slots carry zero data so readdata is zero whenever readdatavalid is low.
  always_comb begin
    pipe_vld_d[0] = acc_read;
    pipe_dat_d[0] = acc_read ? rd_word : 64'd0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_dat_q[i] <= 64'd0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < READ_LATENCY; i++) pipe_dat_q[i] <= pipe_dat_d[i];
    end
  end

  assign readdatavalid = pipe_vld_q[READ_LATENCY-1];
  assign readdata      = pipe_dat_q[READ_LATENCY-1];

  // A set event on the same edge as error_clear wins.
  always_comb begin
    oor_d  = oor_q;
    perr_d = perr_q;
    if (error_clear) begin
      oor_d  = 1'b0;
      perr_d = 1'b0;
    end
    if (accept && addr_oor)  oor_d  = 1'b1;
    if (drop_evt || rw_evt)  perr_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oor_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      oor_q  <= oor_d;
      perr_q <= perr_d;
    end
  end

  assign out_of_range   = oor_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_clarvi_mem_responder.sv
// Randomized self-checking bench: three responder configurations against a queue-based reference model.
`timescale 1ns/1ps
module tb_clarvi_mem_responder;

  localparam int N = 3;

  function automatic int wc_of(input int d);
    case (d)
      0: return 0;
      1: return 0;
      default: return 2;
    endcase
  endfunction

  function automatic int rl_of(input int d);
    case (d)
      0: return 2;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n;
  logic [63:0] addr [N];
  logic        rd   [N];
  logic        wr   [N];
  logic [7:0]  be   [N];
  logic [63:0] wdat [N];
  logic        clr  [N];
  logic        wreq [N];
  logic [63:0] rdat [N];
  logic        rvld [N];
  logic        oor  [N];
  logic        perr [N];

  clarvi_mem_responder #(.DEPTH(1024), .READ_LATENCY(2), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset_n(rst_n), .address(addr[0]), .read(rd[0]), .write(wr[0]),
    .byteenable(be[0]), .writedata(wdat[0]), .waitrequest(wreq[0]), .readdata(rdat[0]),
    .readdatavalid(rvld[0]), .error_clear(clr[0]), .out_of_range(oor[0]), .protocol_error(perr[0]));

  clarvi_mem_responder #(.DEPTH(1024), .READ_LATENCY(3), .WAIT_CYCLES(0)) dut1 (
    .clock(clock), .reset_n(rst_n), .address(addr[1]), .read(rd[1]), .write(wr[1]),
    .byteenable(be[1]), .writedata(wdat[1]), .waitrequest(wreq[1]), .readdata(rdat[1]),
    .readdatavalid(rvld[1]), .error_clear(clr[1]), .out_of_range(oor[1]), .protocol_error(perr[1]));

  clarvi_mem_responder #(.DEPTH(1024), .READ_LATENCY(1), .WAIT_CYCLES(2)) dut2 (
    .clock(clock), .reset_n(rst_n), .address(addr[2]), .read(rd[2]), .write(wr[2]),
    .byteenable(be[2]), .writedata(wdat[2]), .waitrequest(wreq[2]), .readdata(rdat[2]),
    .readdatavalid(rvld[2]), .error_clear(clr[2]), .out_of_range(oor[2]), .protocol_error(perr[2]));

  typedef struct {
    int          d;
    int          due;
    logic [63:0] dat;
  } exp_t;

  exp_t        expq [$];
  exp_t        obs  [$];
  logic [63:0] mmem [N][1024];
  bit          m_oor  [N];
  bit          m_perr [N];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;

  task automatic model_accept(input int d, input bit r, input bit w, input logic [63:0] a,
                              input logic [7:0] b, input logic [63:0] wd);
    bit   o;
    int   idx;
    exp_t e;
    o   = (a[63:3] >= 61'd1024);
    idx = int'(a[12:3]);
    if (o) m_oor[d] = 1'b1;
    if (r && w) m_perr[d] = 1'b1;
    if (w) begin
      if (!o) for (int i = 0; i < 8; i++) if (b[i]) mmem[d][idx][8*i +: 8] = wd[8*i +: 8];
    end else if (r) begin
      e.d   = d;
      e.due = cyc + rl_of(d);
      e.dat = o ? 64'd0 : mmem[d][idx];
      expq.push_back(e);
    end
  endtask

  // Advance one clock; every response channel is compared against the model each cycle.
  task automatic tick();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    for (int d = 0; d < N; d++) begin
      int          idx;
      logic        ev;
      logic [63:0] ed;
      exp_t        e;
      idx = -1;
      for (int k = 0; k < expq.size(); k++) begin
        if (expq[k].d == d) begin
          idx = k;
          break;
        end
      end
      ev = (idx >= 0) && (expq[idx].due == cyc);
      ed = ev ? expq[idx].dat : 64'd0;
      checks++;
      if (rvld[d] !== ev || rdat[d] !== ed) begin
        fails++;
        $display("FAIL resp dut%0d cyc %0d: got vld=%b data=%h, want vld=%b data=%h",
                 d, cyc, rvld[d], rdat[d], ev, ed);
      end
      if (ev) expq.delete(idx);
      if (rvld[d] === 1'b1) begin
        e.d = d; e.due = cyc; e.dat = rdat[d];
        obs.push_back(e);
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Hold a request until accepted, checking the waitrequest pattern each cycle.
  task automatic issue(input int d, input bit r, input bit w, input logic [63:0] a,
                       input logic [7:0] b, input logic [63:0] wd);
    logic ew;
    rd[d] = r; wr[d] = w; addr[d] = a; be[d] = b; wdat[d] = wd;
    for (int k = 0; k <= wc_of(d); k++) begin
      #1;
      ew = (k < wc_of(d));
      checks++;
      if (wreq[d] !== ew) begin
        fails++;
        $display("FAIL waitreq dut%0d wait-cycle %0d: got %b want %b", d, k, wreq[d], ew);
      end
      if (k == wc_of(d)) model_accept(d, r, w, a, b, wd);
      tick();
    end
  endtask

  task automatic idle(input int d);
    rd[d] = 1'b0; wr[d] = 1'b0; be[d] = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < N; d++) begin
      idle(d); addr[d] = 64'd0; wdat[d] = 64'd0; clr[d] = 1'b0;
    end
    rd[0] = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    for (int d = 0; d < N; d++) begin
      checks++;
      if (wreq[d] !== 1'b1 || rvld[d] !== 1'b0 || rdat[d] !== 64'd0 || oor[d] !== 1'b0 || perr[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state dut%0d: got wreq=%b vld=%b data=%h oor=%b perr=%b, want 1 0 0 0 0",
                 d, wreq[d], rvld[d], rdat[d], oor[d], perr[d]);
      end
    end
    rd[0] = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < N; d++) begin
      checks++;
      if (wreq[d] !== 1'b0) begin
        fails++;
        $display("FAIL idle_waitreq dut%0d: got %b want 0", d, wreq[d]);
      end
    end
  endtask

  task automatic test_preset();
    for (int d = 0; d < N; d++) begin
      for (int w = 0; w < 16; w++) issue(d, 1'b0, 1'b1, 64'(w * 8), 8'hFF, {$urandom, $urandom});
      idle(d);
    end
    tick();
  endtask

  task automatic test_write_read();
    int c1, n;
    obs.delete();
    issue(0, 1'b0, 1'b1, 64'h40, 8'hFF, 64'h1122334455667788);
    c1 = cyc;
    issue(0, 1'b1, 1'b0, 64'h40, 8'h00, 64'd0);
    idle(0);
    ticks(4);
    n = 0;
    for (int k = 0; k < obs.size(); k++) begin
      if (obs[k].d == 0) begin
        n++;
        checks++;
        if (obs[k].due != c1 + 2 || obs[k].dat !== 64'h1122334455667788) begin
          fails++;
          $display("FAIL write_read: got data %h at cyc %0d, want 1122334455667788 at cyc %0d",
                   obs[k].dat, obs[k].due, c1 + 2);
        end
      end
    end
    checks++;
    if (n != 1) begin fails++; $display("FAIL write_read_count: got %0d responses want 1", n); end
  endtask

  task automatic read_word0(input logic [63:0] a, input logic [63:0] want, input string nm);
    obs.delete();
    issue(0, 1'b1, 1'b0, a, 8'h00, 64'd0);
    idle(0);
    ticks(3);
    checks++;
    if (obs.size() != 1 || obs[0].dat !== want) begin
      fails++;
      $display("FAIL %s: got %0d responses, data %h, want one with %h", nm, obs.size(),
               (obs.size() > 0) ? obs[0].dat : 64'hx, want);
    end
  endtask

  task automatic test_byte_lanes();
    issue(0, 1'b0, 1'b1, 64'h48, 8'hFF, 64'd0);
    issue(0, 1'b0, 1'b1, 64'h48, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    read_word0(64'h48, 64'h0000_0000_FFFF_FFFF, "lanes_low");
    issue(0, 1'b0, 1'b1, 64'h4F, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA);
    read_word0(64'h48, 64'h0000_0000_FFFF_FFFF, "lanes_none");
    issue(0, 1'b0, 1'b1, 64'h48, 8'h81, 64'h5555_5555_5555_5555);
    read_word0(64'h4B, 64'h5500_0000_FFFF_FF55, "lanes_edge");
  endtask

  task automatic test_wait_states();
    issue(2, 1'b0, 1'b1, 64'h8, 8'hFF, 64'hCAFE_F00D_0000_0008);
    idle(2);
    tick();
    issue(2, 1'b1, 1'b0, 64'h8, 8'h00, 64'd0);
    checks++;
    if (rvld[2] !== 1'b1 || rdat[2] !== 64'hCAFE_F00D_0000_0008) begin
      fails++;
      $display("FAIL wait_read: got vld=%b data=%h want 1 cafef00d00000008", rvld[2], rdat[2]);
    end
    issue(2, 1'b1, 1'b0, 64'h8, 8'h00, 64'd0);
    issue(2, 1'b1, 1'b0, 64'h10, 8'h00, 64'd0);
    idle(2);
    ticks(2);
  endtask

  task automatic test_back_to_back();
    int s, n;
    for (int i = 0; i < 4; i++) issue(1, 1'b0, 1'b1, 64'(8 * i), 8'hFF, 64'(10 * (i + 1)));
    obs.delete();
    s = cyc;
    for (int i = 0; i < 4; i++) issue(1, 1'b1, 1'b0, 64'(8 * i), 8'h00, 64'd0);
    idle(1);
    ticks(6);
    n = 0;
    for (int k = 0; k < obs.size(); k++) begin
      if (obs[k].d == 1) begin
        checks++;
        if (obs[k].due != s + 3 + n || obs[k].dat !== 64'(10 * (n + 1))) begin
          fails++;
          $display("FAIL b2b_resp%0d: got %0d at cyc %0d, want %0d at cyc %0d",
                   n, obs[k].dat, obs[k].due, 10 * (n + 1), s + 3 + n);
        end
        n++;
      end
    end
    checks++;
    if (n != 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", n); end
  endtask

  task automatic check_flags(input int d, input string nm);
    checks++;
    if (oor[d] !== m_oor[d] || perr[d] !== m_perr[d]) begin
      fails++;
      $display("FAIL %s dut%0d: got oor=%b perr=%b want oor=%b perr=%b",
               nm, d, oor[d], perr[d], m_oor[d], m_perr[d]);
    end
  endtask

  task automatic clear_flags(input int d);
    clr[d] = 1'b1;
    tick();
    clr[d] = 1'b0;
    m_oor[d] = 1'b0; m_perr[d] = 1'b0;
  endtask

  task automatic test_out_of_range();
    issue(0, 1'b0, 1'b1, 64'h1FF8, 8'hFF, 64'h0BAD_BEEF_0000_1023);
    read_word0(64'h1FF8, 64'h0BAD_BEEF_0000_1023, "top_word");
    check_flags(0, "oor_top_word");
    read_word0(64'h2000, 64'd0, "oor_read");
    check_flags(0, "oor_set");
    clear_flags(0);
    check_flags(0, "oor_clear");
    issue(0, 1'b0, 1'b1, 64'h2000, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD);
    idle(0);
    check_flags(0, "oor_write");
    read_word0(64'h0, mmem[0][0], "oor_discard");
    clr[0] = 1'b1;
    issue(0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 8'h00, 64'd0);
    clr[0] = 1'b0;
    idle(0);
    check_flags(0, "oor_set_wins");
    ticks(2);
    clear_flags(0);
    check_flags(0, "oor_clear2");
  endtask

  task automatic test_protocol();
    issue(0, 1'b1, 1'b1, 64'h50, 8'hFF, 64'h0123_4567_89AB_CDEF);
    idle(0);
    check_flags(0, "perr_rw");
    ticks(3);
    read_word0(64'h50, 64'h0123_4567_89AB_CDEF, "rw_is_write");
    clear_flags(0);
    check_flags(0, "perr_clear");
    rd[2] = 1'b1; addr[2] = 64'h8;
    tick();
    rd[2] = 1'b0;
    tick();
    m_perr[2] = 1'b1;
    check_flags(2, "perr_drop");
    issue(2, 1'b1, 1'b0, 64'h8, 8'h00, 64'd0);
    idle(2);
    tick();
    clear_flags(2);
    check_flags(2, "perr_drop_clear");
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) issue(1, 1'b1, 1'b0, 64'(8 * i), 8'h00, 64'd0);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rvld[1] !== 1'b0 || rdat[1] !== 64'd0) begin
      fails++;
      $display("FAIL reset_async: got vld=%b data=%h want 0 0", rvld[1], rdat[1]);
    end
    expq.delete();
    for (int d = 0; d < N; d++) begin m_oor[d] = 1'b0; m_perr[d] = 1'b0; end
    tick();
    rst_n = 1'b1;
    obs.delete();
    ticks(6);
    checks++;
    if (obs.size() != 0) begin
      fails++;
      $display("FAIL reset_discard: got %0d responses after release want 0", obs.size());
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < N; d++) begin
      for (int n = 0; n < 150; n++) begin
        bit          r, w;
        logic [63:0] a;
        if ($urandom_range(0, 7) == 0) begin
          idle(d);
          tick();
        end else begin
          w = 1'($urandom_range(0, 1));
          r = !w;
          if ($urandom_range(0, 31) == 0) begin r = 1'b1; w = 1'b1; end
          if ($urandom_range(0, 19) == 0) a = 64'h2000 + 64'($urandom);
          else a = 64'(($urandom_range(0, 15) << 3) | $urandom_range(0, 7));
          issue(d, r, w, a, 8'($urandom), {$urandom, $urandom});
        end
      end
      idle(d);
      ticks(5);
      check_flags(d, "random_flags");
      clear_flags(d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_preset();
    test_write_read();
    test_byte_lanes();
    test_wait_states();
    test_back_to_back();
    test_out_of_range();
    test_protocol();
    test_reset_midflight();
    test_random();
    ticks(4);
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL pending: %0d expected responses never arrived, want 0", expq.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
